// File: rtl/wfull_ctl.sv
// rtl/wfull_ctl.sv - write-side full/level control for an async Gray-pointer FIFO
module wfull_ctl #(
  parameter int ADDRSIZE     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 2**ADDRSIZE - 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wfull,
  output logic                wafull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wovf
);

  localparam logic [ADDRSIZE:0] AFULL_LVL = (ADDRSIZE+1)'(AFULL_THRESH);

  logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
  logic [ADDRSIZE:0] wq_rptr;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] full_ptr;
  logic              wpush;

  // Plain flop chain: no logic between stages so each bit resolves independently.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wq_rptr = sync_q[SYNC_STAGES-1];

  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDRSIZE; i++) rbin[i] = ^(wq_rptr >> i);
  end

  assign wpush      = winc & ~wfull;
  assign wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wpush};
  assign wgraynext  = (wbinnext >> 1) ^ wbinnext;
  assign level_next = wbinnext - rbin;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_ptr   = {~wq_rptr[ADDRSIZE:ADDRSIZE-1], wq_rptr[ADDRSIZE-2:0]};
  assign waddr      = wbin[ADDRSIZE-1:0];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin   <= '0;
      wptr   <= '0;
      wfull  <= 1'b0;
      wafull <= 1'b0;
      wlevel <= '0;
      wovf   <= 1'b0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wfull  <= (wgraynext == full_ptr);
      wafull <= (level_next >= AFULL_LVL);
      wlevel <= level_next;
      if (winc && wfull)
        wovf <= 1'b1;
      else if (wovf_clr)
        wovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wfull_ctl.sv
// tb/tb_wfull_ctl.sv - directed self-checking bench for wfull_ctl
module tb_wfull_ctl;

  logic       wclk;
  logic       wrst_n;
  logic       winc;
  logic [4:0] rptr;
  logic       wovf_clr;
  logic [4:0] wptr;
  logic [3:0] waddr;
  logic       wfull;
  logic       wafull;
  logic [4:0] wlevel;
  logic       wovf;

  int vectors;
  int miscompares;

  wfull_ctl #(.ADDRSIZE(4), .SYNC_STAGES(2), .AFULL_THRESH(14)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr(rptr), .wovf_clr(wovf_clr),
    .wptr(wptr), .waddr(waddr), .wfull(wfull), .wafull(wafull),
    .wlevel(wlevel), .wovf(wovf)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wptr"},   32'(wptr),   0);
    chk({tag, ".waddr"},  32'(waddr),  0);
    chk({tag, ".wlevel"}, 32'(wlevel), 0);
    chk({tag, ".wfull"},  32'(wfull),  0);
    chk({tag, ".wafull"}, 32'(wafull), 0);
    chk({tag, ".wovf"},   32'(wovf),   0);
  endtask

  logic [4:0] m_wb, m_rq0, m_rq1, m_nb, rd;
  logic       m_full, m_push;
  logic [4:0] exp_level;
  logic       exp_full;

  initial begin
    vectors = 0;
    miscompares = 0;
    wrst_n = 1'b0;
    winc = 1'b0;
    rptr = 5'b00000;
    wovf_clr = 1'b0;
    #12;
    chk_all_zero("reset");
    step();
    wrst_n = 1'b1;

    // Fill from empty with the read side parked at 0.
    winc = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("fill%0d.wlevel", i), 32'(wlevel), i);
      chk($sformatf("fill%0d.wafull", i), 32'(wafull), (i >= 14) ? 1 : 0);
      chk($sformatf("fill%0d.wfull", i),  32'(wfull),  (i == 16) ? 1 : 0);
      chk($sformatf("fill%0d.waddr", i),  32'(waddr),  i % 16);
      chk($sformatf("fill%0d.wptr", i),   32'(wptr),   i ^ (i >> 1));
    end

    step();
    chk("ovf.wptr",   32'(wptr),   32'b11000);
    chk("ovf.wlevel", 32'(wlevel), 16);
    chk("ovf.waddr",  32'(waddr),  0);
    chk("ovf.wovf",   32'(wovf),   1);
    winc = 1'b0;
    wovf_clr = 1'b1;
    step();
    chk("ovfclr.wovf", 32'(wovf), 0);
    winc = 1'b1;
    step();
    chk("ovfboth.wovf", 32'(wovf), 1);
    chk("ovfboth.wptr", 32'(wptr), 32'b11000);
    winc = 1'b0;
    step();
    chk("ovfclr2.wovf", 32'(wovf), 0);
    wovf_clr = 1'b0;

    // Read pointer advance must take two edges to reach the flags.
    rptr = 5'b00001;
    step();
    chk("rdK.wfull",   32'(wfull),  1);
    chk("rdK.wlevel",  32'(wlevel), 16);
    step();
    chk("rdK1.wfull",  32'(wfull),  1);
    chk("rdK1.wlevel", 32'(wlevel), 16);
    step();
    chk("rdK2.wfull",  32'(wfull),  0);
    chk("rdK2.wlevel", 32'(wlevel), 15);
    chk("rdK2.wafull", 32'(wafull), 1);

    for (int r = 2; r <= 7; r++) begin
      rptr = b2g(5'(r));
      step();
    end
    step();
    step();
    chk("lvl9.wlevel", 32'(wlevel), 9);
    chk("lvl9.wafull", 32'(wafull), 0);
    chk("lvl9.wfull",  32'(wfull),  0);

    // Asynchronous reset between edges.
    #2;
    wrst_n = 1'b0;
    #1;
    chk_all_zero("areset");
    rptr = 5'b00000;
    step();
    chk_all_zero("areset_hold");
    #2;
    wrst_n = 1'b1;
    step();
    chk_all_zero("post_reset");

    // 32 pushes against a draining reader; pointer wraps back to 0.
    m_wb = '0; m_rq0 = '0; m_rq1 = '0; m_full = 1'b0; rd = '0;
    winc = 1'b1;
    chk("first_push.waddr", 32'(waddr), 0);
    for (int i = 0; i < 32; i++) begin
      m_push    = winc & ~m_full;
      m_nb      = m_wb + 5'(m_push);
      exp_level = m_nb - g2b(m_rq1);
      exp_full  = (b2g(m_nb) == {~m_rq1[4:3], m_rq1[2:0]});
      m_rq1     = m_rq0;
      m_rq0     = rptr;
      m_wb      = m_nb;
      m_full    = exp_full;
      step();
      chk($sformatf("wrap%0d.wlevel", i), 32'(wlevel), 32'(exp_level));
      chk($sformatf("wrap%0d.wfull", i),  32'(wfull),  0);
      chk($sformatf("wrap%0d.wafull", i), 32'(wafull), (exp_level >= 5'd14) ? 1 : 0);
      chk($sformatf("wrap%0d.wptr", i),   32'(wptr),   32'(b2g(m_wb)));
      if (m_wb != rd) rd = rd + 5'd1;
      rptr = b2g(rd);
    end
    winc = 1'b0;
    chk("wrap_end.wptr",  32'(wptr),  0);
    chk("wrap_end.waddr", 32'(waddr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
